// File: rtl/packet_store.sv
// rtl/packet_store.sv - AXI-Stream packet capture into a circular packet RAM with descriptor output
//
// Accepts packets on an AXI-Stream slave, stores each beat in a circular RAM
// of 2**ADDR_WIDTH words and, once a packet is complete, presents a
// descriptor (first-beat address, byte length) on a valid/ready port. The
// consumer reads beats through a registered read port and hands space back
// through the release port, oldest packet first. Packets longer than
// MAX_PKT_BEATS are discarded and reported with a one-cycle drop pulse.
//
// Optional feature macro: PACKET_STORE_STATS_EN adds packet/drop counters.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s_axis_t*           stream slave: tdata, tkeep, tvalid, tlast in; tready out
//   desc_valid_o        descriptor valid
//   desc_ready_i        descriptor accept
//   desc_addr_o         RAM address of the packet's first beat
//   desc_pkt_len_o      packet length in bytes
//   rd_addr_i           read address
//   rd_data_o           read data, one cycle after rd_addr_i
//   rel_valid_i         release strobe
//   rel_beats_i         number of beats handed back
//   drop_o              one-cycle pulse per discarded packet
//   pkt_cnt_o           (stats build) descriptor handshakes, wraps at 2**32
//   drop_cnt_o          (stats build) drop pulses, wraps at 2**32

`timescale 1ns/1ps

module packet_store #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int MAX_PKT_BEATS   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic                       desc_valid_o,
  input  logic                       desc_ready_i,
  output logic [ADDR_WIDTH-1:0]      desc_addr_o,
  output logic [15:0]                desc_pkt_len_o,
  input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
  output logic [AXIS_DATA_WIDTH-1:0] rd_data_o,
  input  logic                       rel_valid_i,
  input  logic [ADDR_WIDTH:0]        rel_beats_i,
`ifdef PACKET_STORE_STATS_EN
  output logic [31:0]                pkt_cnt_o,
  output logic [31:0]                drop_cnt_o,
`endif
  output logic                       drop_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Wide enough for free + a full release + a drop restore without wrapping.
  localparam int FW    = ADDR_WIDTH + 3;
  localparam int BCW   = $clog2(MAX_PKT_BEATS + 1);
  localparam int KCW   = $clog2(AXIS_KEEP_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] FREE_FULL = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DESC = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;

  logic [ADDR_WIDTH-1:0]    wr_ptr;
  logic [ADDR_WIDTH-1:0]    start_ptr;
  logic [BCW-1:0]           beat_cnt;
  logic [15:0]              byte_cnt;
  logic [ADDR_WIDTH:0]      free;
  logic [ADDR_WIDTH:0]      free_next;
  logic [FW-1:0]            free_sum;

  logic [KCW-1:0]           keep_bytes;
  logic [15:0]              pkt_bytes;
  logic                     beat_acc;
  logic                     recv_beat;
  logic                     pkt_overflow;
  logic                     wr_en;
  logic                     drop_done;

  logic [AXIS_DATA_WIDTH-1:0] mem [DEPTH];

  // Beat classification
  assign beat_acc     = s_axis_tvalid && s_axis_tready;
  assign recv_beat    = beat_acc && (state == S_RECV);
  // The beat that would push the count past the limit is never written.
  assign pkt_overflow = recv_beat && (beat_cnt == BCW'(MAX_PKT_BEATS));
  assign wr_en        = recv_beat && !pkt_overflow;
  assign pkt_bytes    = byte_cnt + 16'(keep_bytes);
  assign drop_done    = (pkt_overflow && s_axis_tlast) ||
                        ((state == S_DROP) && beat_acc && s_axis_tlast);

  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      keep_bytes = keep_bytes + KCW'(s_axis_tkeep[i]);
    end
  end

  // Free-space accounting: write, release and drop restore can all land in
  // the same cycle; the result never exceeds the RAM depth.
  always_comb begin
    free_sum = FW'(free) - FW'(wr_en)
             + (rel_valid_i ? FW'(rel_beats_i) : '0)
             + (pkt_overflow ? FW'(beat_cnt) : '0);
    if (free_sum > FW'(DEPTH)) begin
      free_next = FREE_FULL;
    end else begin
      free_next = free_sum[ADDR_WIDTH:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_RECV;
      S_RECV: begin
        if (pkt_overflow) begin
          state_next = s_axis_tlast ? S_IDLE : S_DROP;
        end else if (recv_beat && s_axis_tlast) begin
          state_next = S_DESC;
        end
      end
      S_DESC: begin
        if (desc_ready_i) begin
          state_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (beat_acc && s_axis_tlast) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Depends only on registered state, never on tvalid.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      S_RECV:  s_axis_tready = (free != '0);
      S_DROP:  s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Pointers, counters and descriptor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      start_ptr      <= '0;
      beat_cnt       <= '0;
      byte_cnt       <= '0;
      free           <= FREE_FULL;
      desc_valid_o   <= 1'b0;
      desc_addr_o    <= '0;
      desc_pkt_len_o <= '0;
      drop_o         <= 1'b0;
    end else begin
      free   <= free_next;
      drop_o <= drop_done;
      case (state)
        S_IDLE: begin
          start_ptr <= wr_ptr;
          beat_cnt  <= '0;
          byte_cnt  <= '0;
        end
        S_RECV: begin
          if (pkt_overflow) begin
            // Rewind so the next packet reuses the discarded space.
            wr_ptr <= start_ptr;
          end else if (wr_en) begin
            wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt + BCW'(1);
            byte_cnt <= pkt_bytes;
            if (s_axis_tlast) begin
              desc_valid_o   <= 1'b1;
              desc_addr_o    <= start_ptr;
              desc_pkt_len_o <= pkt_bytes;
            end
          end
        end
        S_DESC: begin
          if (desc_ready_i) begin
            desc_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Packet RAM: no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  // Registered read; a same-cycle write to the same address returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

`ifdef PACKET_STORE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (desc_valid_o && desc_ready_i) begin
        pkt_cnt_o <= pkt_cnt_o + 32'd1;
      end
      if (drop_o) begin
        drop_cnt_o <= drop_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_store.sv
// tb/tb_packet_store.sv - self-checking bench for packet_store

`timescale 1ns/1ps

module tb_packet_store;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int AW    = 8;
  localparam int MAXB  = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          desc_valid_o;
  logic          desc_ready_i;
  logic [AW-1:0] desc_addr_o;
  logic [15:0]   desc_pkt_len_o;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rel_valid_i;
  logic [AW:0]   rel_beats_i;
  logic          drop_o;
`ifdef PACKET_STORE_STATS_EN
  logic [31:0]   pkt_cnt_o;
  logic [31:0]   drop_cnt_o;
`endif

  packet_store dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .desc_valid_o   (desc_valid_o),
    .desc_ready_i   (desc_ready_i),
    .desc_addr_o    (desc_addr_o),
    .desc_pkt_len_o (desc_pkt_len_o),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .rel_valid_i    (rel_valid_i),
    .rel_beats_i    (rel_beats_i),
`ifdef PACKET_STORE_STATS_EN
    .pkt_cnt_o      (pkt_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
`endif
    .drop_o         (drop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored beat contents, next free slot, expected events.
  logic [DW-1:0] mm [DEPTH];
  int mptr       = 0;
  int exp_drops  = 0;
  int drop_cycles = 0;
  int stat_pkts  = 0;
  int stat_drops = 0;

  typedef struct {
    int          nbeats;
    logic [KW-1:0] last_keep;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_len;
    bit            exp_drop;
  } vec_t;

  vec_t vecs [6];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && drop_o === 1'b1) drop_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    desc_ready_i  = 1'b0;
    rel_valid_i   = 1'b0;
    rel_beats_i   = '0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    mptr       = 0;
    stat_pkts  = 0;
    stat_drops = 0;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (s_axis_tready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_pkt(input int nbeats, input logic [KW-1:0] last_keep, input bit rand_keep,
                          input bit gaps, output int bytes);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    bytes = 0;
    for (int b = 0; b < nbeats; b++) begin
      d = rand_data();
      if (rand_keep) k = {$urandom, $urandom};
      else k = (b == nbeats - 1) ? last_keep : '1;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      send_beat(d, k, b == nbeats - 1);
      if (nbeats <= MAXB) mm[(mptr + b) % DEPTH] = d;
      bytes += $countones(k);
    end
  endtask

  task automatic finish_pkt(input bit is_drop, input int nbeats, input logic [AW-1:0] exp_addr,
                            input logic [15:0] exp_len, input int delay, input bit do_rel,
                            input string tag);
    if (is_drop) begin
      check({tag, "_drop_pulse"}, drop_o, 1);
      check({tag, "_no_desc"}, desc_valid_o, 0);
      exp_drops++;
      stat_drops++;
      @(negedge clk);
      check({tag, "_drop_end"}, drop_o, 0);
      check({tag, "_no_desc_after"}, desc_valid_o, 0);
    end else begin
      check({tag, "_desc_valid"}, desc_valid_o, 1);
      check({tag, "_desc_addr"}, desc_addr_o, exp_addr);
      check({tag, "_desc_len"}, desc_pkt_len_o, exp_len);
      check({tag, "_no_drop"}, drop_o, 0);
      for (int c = 0; c < delay; c++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, desc_valid_o, 1);
        check({tag, "_hold_addr"}, desc_addr_o, exp_addr);
        check({tag, "_hold_len"}, desc_pkt_len_o, exp_len);
        check({tag, "_hold_tready"}, s_axis_tready, 0);
      end
      desc_ready_i = 1'b1;
      @(negedge clk);
      desc_ready_i = 1'b0;
      check({tag, "_desc_cleared"}, desc_valid_o, 0);
      stat_pkts++;
      for (int b = 0; b < nbeats; b++) begin
        rd_addr_i = AW'((mptr + b) % DEPTH);
        @(negedge clk);
        check({tag, "_readback"}, rd_data_o, mm[(mptr + b) % DEPTH]);
      end
      if (do_rel) begin
        rel_valid_i = 1'b1;
        rel_beats_i = (AW+1)'(nbeats);
        @(negedge clk);
        rel_valid_i = 1'b0;
      end
      mptr = (mptr + nbeats) % DEPTH;
    end
  endtask

  initial begin
    int            bytes;
    int            n;
    int            acc;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] c_data [16];

    vecs[0] = '{3,  64'h0000_0000_0000_FFFF, 8'd0,  16'd144,  1'b0};
    vecs[1] = '{1,  64'hFFFF_FFFF_FFFF_FFFF, 8'd3,  16'd64,   1'b0};
    vecs[2] = '{1,  64'h0000_0000_0000_0000, 8'd4,  16'd0,    1'b0};
    vecs[3] = '{32, 64'hFFFF_FFFF_FFFF_FFFF, 8'd5,  16'd2048, 1'b0};
    vecs[4] = '{33, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0,  16'd0,    1'b1};
    vecs[5] = '{2,  64'h0000_0000_0000_0001, 8'd37, 16'd65,   1'b0};

    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    desc_ready_i  = 1'b0;
    rd_addr_i     = '0;
    rel_valid_i   = 1'b0;
    rel_beats_i   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_desc_valid", desc_valid_o, 0);
    check("rst_drop", drop_o, 0);
    check("rst_desc_addr", desc_addr_o, 0);
    check("rst_desc_len", desc_pkt_len_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    rst_n = 1'b1;
    check("idle_tready", s_axis_tready, 0);
    @(negedge clk);
    check("recv_tready", s_axis_tready, 1);

    // Table-driven packets
    for (int i = 0; i < 6; i++) begin
      send_pkt(vecs[i].nbeats, vecs[i].last_keep, 1'b0, 1'b0, bytes);
      finish_pkt(vecs[i].exp_drop, vecs[i].nbeats, vecs[i].exp_addr, vecs[i].exp_len, 0, 1'b1, "tbl");
    end

    // Descriptor backpressure with the next packet waiting
    do_reset();
    d1 = rand_data();
    d2 = rand_data();
    send_beat(d1, '1, 1'b1);
    mm[0] = d1;
    s_axis_tdata  = d2;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("A_hold_tready", s_axis_tready, 0);
      check("A_hold_valid", desc_valid_o, 1);
      check("A_hold_addr", desc_addr_o, 0);
      check("A_hold_len", desc_pkt_len_o, 64);
      @(negedge clk);
    end
    desc_ready_i = 1'b1;
    @(negedge clk);
    desc_ready_i = 1'b0;
    rel_valid_i  = 1'b1;
    rel_beats_i  = 9'd1;
    @(negedge clk);
    rel_valid_i = 1'b0;
    mptr = 1;
    send_beat(d2, '1, 1'b1);
    mm[1] = d2;
    finish_pkt(1'b0, 1, 8'd1, 16'd64, 0, 1'b1, "A2");

    // Oversized packet dropped, next packet reuses its space
    send_pkt(40, '1, 1'b0, 1'b0, bytes);
    finish_pkt(1'b1, 40, 8'd0, 16'd0, 0, 1'b1, "B_drop");
    send_pkt(2, '1, 1'b0, 1'b0, bytes);
    finish_pkt(1'b0, 2, 8'd2, 16'd128, 1, 1'b1, "B_next");

    // Fill the whole RAM without release
    do_reset();
    for (int p = 0; p < 8; p++) begin
      send_pkt(32, '1, 1'b0, 1'b0, bytes);
      finish_pkt(1'b0, 32, AW'(p * 32), 16'd2048, 0, 1'b0, "C_fill");
    end
    for (int i = 0; i < 16; i++) c_data[i] = rand_data();
    acc           = 0;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s_axis_tdata = c_data[acc];
      if (s_axis_tready && acc < 15) acc++;
      @(negedge clk);
    end
    check("C_full_stall_beats", acc, 0);
    check("C_full_tready", s_axis_tready, 0);
    s_axis_tdata = c_data[acc];
    rel_valid_i  = 1'b1;
    rel_beats_i  = 9'd4;
    if (s_axis_tready && acc < 15) acc++;
    @(negedge clk);
    rel_valid_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      s_axis_tdata = c_data[acc];
      if (s_axis_tready && acc < 15) acc++;
      @(negedge clk);
    end
    check("C_after_rel4_beats", acc, 4);
    check("C_after_rel4_tready", s_axis_tready, 0);

    // Release in the same cycle as the write that would empty free space
    s_axis_tdata = c_data[acc];
    rel_valid_i  = 1'b1;
    rel_beats_i  = 9'd1;
    @(negedge clk);
    rel_valid_i = 1'b0;
    check("D_free1_tready", s_axis_tready, 1);
    s_axis_tdata = c_data[acc];
    rel_valid_i  = 1'b1;
    rel_beats_i  = 9'd1;
    if (s_axis_tready && acc < 15) acc++;
    @(negedge clk);
    rel_valid_i = 1'b0;
    check("D_same_cycle_tready", s_axis_tready, 1);
    s_axis_tdata = c_data[acc];
    s_axis_tlast = 1'b1;
    if (s_axis_tready && acc < 15) acc++;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("D_total_beats", acc, 6);
    for (int i = 0; i < 6; i++) mm[i] = c_data[i];
    finish_pkt(1'b0, 6, 8'd0, 16'd384, 0, 1'b1, "D_wrap");

    // Reset in the middle of a packet
    do_reset();
    send_beat(rand_data(), '1, 1'b0);
    send_beat(rand_data(), '1, 1'b0);
    s_axis_tdata  = rand_data();
    s_axis_tvalid = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("E_rst_tready", s_axis_tready, 0);
    check("E_rst_desc_valid", desc_valid_o, 0);
    repeat (2) @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n         = 1'b1;
    mptr          = 0;
    stat_pkts     = 0;
    stat_drops    = 0;
    @(negedge clk);
    send_pkt(1, '1, 1'b0, 1'b0, bytes);
    finish_pkt(1'b0, 1, 8'd0, 16'd64, 0, 1'b1, "E_after");

    // Randomized packets against the reference model
    for (int p = 0; p < 30; p++) begin
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(33, 40)) : int'($urandom_range(1, 32));
      send_pkt(n, '1, 1'b1, 1'b1, bytes);
      finish_pkt(n > MAXB, n, AW'(mptr), 16'(bytes), int'($urandom_range(0, 3)), 1'b1, "rnd");
    end

    repeat (2) @(negedge clk);
    check("drop_pulse_cycles", drop_cycles, exp_drops);
`ifdef PACKET_STORE_STATS_EN
    check("stats_pkt_cnt", pkt_cnt_o, stat_pkts);
    check("stats_drop_cnt", drop_cnt_o, stat_drops);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
